err_comp_accum: RTL and testbench
=================================

# err_comp_accum

Consumer end of the rounded error-product path in the error-compensation MAC. It receives truncated error-product codes, one per MAC step, produced by the upstream rounding stage. Each code is expanded back to its 16-bit signed weight, and the block accumulates the codes over a frame (one output neuron / dot product). On the frame's last beat it presents a single saturated correction word to the MAC output adder through a valid/ready handshake.

## Interface
- KEEP, 14, code width: the retained upper bits [15:16-KEEP] of the 16-bit rounded error product
- DROP, 16-KEEP (derived, not overridable), zero bits restored below the code
- ACC_W, 24, accumulator and correction width; ACC_W >= 17 required
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- s_valid  input  1  code beat valid
- s_ready  output  1  block can accept a code beat
- s_code  input  KEEP  truncated error-product code, two's complement (bit KEEP-1 = sign)
- s_last  input  1  beat is the last of the frame
- m_valid  output  1  correction word valid
- m_ready  input  1  downstream accepts correction
- m_corr  output  ACC_W  signed sum of the frame's expanded error products, saturated
- m_count  output  8  beats in the frame, saturating at 255
- m_sat  output  1  accumulator saturated at least once during the frame

## Operation
- Expansion: value = sign_extend_to_ACC_W({s_code, DROP'b0}). With KEEP=14, code 14'h0001 expands to +4 and 14'h3FFF expands to -4.
- State machine has two states.
  - ACCUM: reset state. s_ready=1, m_valid=0.
  - HOLD: s_ready=0, m_valid=1.
- ACCUM, accepted beat (s_valid & s_ready):
  - acc <= sat(acc + value).
  - cnt <= min(cnt+1, 255).
  - sat_flag sets if the clamp engaged.
  - If s_last=1, also capture the updated acc, cnt and sat_flag into the output registers and move to HOLD.
- Saturation:
  - Compute the exact ACC_W+1-bit sum.
  - Positive overflow clamps to 2^(ACC_W-1)-1.
  - Negative overflow clamps to -2^(ACC_W-1).
  - Once saturated, later beats continue to accumulate from the clamped value.
- HOLD:
  - m_corr, m_count and m_sat stay stable until m_valid & m_ready.
  - On that handshake, acc, cnt and sat_flag clear to 0 and the state returns to ACCUM.
  - The output registers keep their last value.
- s_valid while s_ready=0 is ignored. The source holds the beat until it is accepted.
- A single-beat frame (first beat has s_last=1) is legal: m_count=1.
- An all-zero frame of N beats gives m_corr=0 and m_count=N.
- m_count saturates at 255. The accumulator is unaffected by count saturation.

## Timing
- Reset (asynchronous assert, synchronous deassert taken care of externally):
  - state=ACCUM, acc=0, cnt=0, sat_flag=0.
  - s_ready=1, m_valid=0, m_corr=0, m_count=0, m_sat=0.
- Throughput in ACCUM: one beat per cycle.
- Latency: last beat accepted at edge N gives m_valid=1 from edge N through the cycle after.
  - If m_ready=1 in the first HOLD cycle, the handshake completes at edge N+1.
  - s_ready returns to 1 after edge N+1.
  - Minimum frame-to-frame bubble is one cycle.
- s_ready depends only on state (registered). There is no combinational path from m_ready to s_ready.
- Reset asserted mid-frame or in HOLD: the partial sum and pending correction are discarded, and all outputs take their reset values immediately.
- m_ready held low: HOLD persists indefinitely and no input is accepted.

## Test plan
- Reset: assert rst_n=0 mid-frame after 3 beats -> outputs immediately at reset values, s_ready=1. The next frame of codes {1,1} with last -> m_corr=8, m_count=2.
- Basic frame, KEEP=14: codes {14'h0001, 14'h0002, 14'h3FFF(last)} -> m_corr=+8, m_count=3, m_sat=0, m_valid one cycle after the last beat.
- Backpressure: hold m_ready=0 for 5 cycles while s_valid=1 -> s_ready=0 throughout, m_corr stable. Then m_ready=1 -> handshake, and the next frame starts from acc=0.
- Saturation, ACC_W=17:
  - 3 beats of 14'h1FFF (+32764 each) -> m_corr=65535, m_sat=1.
  - Following frame {14'h2000} (-32768) -> m_corr=-32768, m_sat=0.
- Count saturation: 300 beats of code 0, last on beat 300 -> m_count=255, m_corr=0.
- Single-beat and back-to-back frames: frames {5(last)}, {3(last)} with m_ready=1 always -> corrections 20 and 12. There is a one-cycle s_ready gap between the frames.

Source files
------------

// File: rtl/err_comp_accum.sv
// Accumulates truncated error-product codes over a frame and hands one
// saturated correction word per frame to the MAC output adder.
module err_comp_accum #(
  parameter int KEEP  = 14,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [KEEP-1:0]    s_code,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ACC_W-1:0]   m_corr,
  output logic [7:0]         m_count,
  output logic               m_sat
);

  localparam int DROP = 16 - KEEP;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             satf_q, satf_d;
  logic [ACC_W-1:0] corr_q, corr_d;
  logic [7:0]       count_q, count_d;
  logic             msat_q, msat_d;

  // Restore the dropped low zeros, then sign-extend the 16-bit product.
  logic [15:0]      prod16;
  logic [ACC_W-1:0] val;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       cnt_inc;

  assign prod16  = 16'(s_code) << DROP;
  assign val     = {{(ACC_W-16){prod16[15]}}, prod16};
  assign sum     = {acc_q[ACC_W-1], acc_q} + {val[ACC_W-1], val};
  assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_sum = !ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    satf_d  = satf_q;
    corr_d  = corr_q;
    count_d = count_q;
    msat_d  = msat_q;
    if (state_q == ST_ACCUM) begin
      if (s_valid) begin
        acc_d  = acc_sum;
        cnt_d  = cnt_inc;
        satf_d = satf_q | ovf;
        if (s_last) begin
          corr_d  = acc_sum;
          count_d = cnt_inc;
          msat_d  = satf_q | ovf;
          state_d = ST_HOLD;
        end
      end
    end else if (m_ready) begin
      acc_d   = '0;
      cnt_d   = '0;
      satf_d  = 1'b0;
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      satf_q  <= 1'b0;
      corr_q  <= '0;
      count_q <= '0;
      msat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      satf_q  <= satf_d;
      corr_q  <= corr_d;
      count_q <= count_d;
      msat_q  <= msat_d;
    end
  end

  assign s_ready = (state_q == ST_ACCUM);
  assign m_valid = (state_q == ST_HOLD);
  assign m_corr  = corr_q;
  assign m_count = count_q;
  assign m_sat   = msat_q;

endmodule

// File: tb/tb_err_comp_accum.sv
// Directed bench for err_comp_accum (ACC_W=17) with a frame scoreboard.
module tb_err_comp_accum;
  localparam int KEEP  = 14;
  localparam int ACC_W = 17;
  localparam int AMAX  = (1 << (ACC_W-1)) - 1;
  localparam int AMIN  = -(1 << (ACC_W-1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_last, m_ready;
  logic [KEEP-1:0]   s_code;
  logic              s_ready, m_valid, m_sat;
  logic [ACC_W-1:0]  m_corr;
  logic [7:0]        m_count;

  typedef struct {
    logic [ACC_W-1:0] corr;
    logic [7:0]       cnt;
    logic             sat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   last_wait;
  int   m_acc, m_cnt;
  bit   m_satf;

  err_comp_accum #(.KEEP(KEEP), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_corr(m_corr), .m_count(m_count), .m_sat(m_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat from posedge+1 and wait (bounded) for acceptance.
  task automatic send(input logic [KEEP-1:0] code, input logic last);
    int w = 0;
    bit ok = 0;
    int v, s;
    exp_t e;
    s_valid = 1'b1; s_code = code; s_last = last;
    while (!ok && w < 100) begin
      @(negedge clk);
      if (s_ready) ok = 1; else w++;
      @(posedge clk);
    end
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    last_wait = w;
    check("accept", 32'(ok), 32'd1);
    if (ok) begin
      v = int'($signed(code)) * 4;
      s = m_acc + v;
      if (s > AMAX) begin s = AMAX; m_satf = 1; end
      else if (s < AMIN) begin s = AMIN; m_satf = 1; end
      m_acc = s;
      if (m_cnt < 255) m_cnt++;
      if (last) begin
        e.corr = ACC_W'(m_acc); e.cnt = 8'(m_cnt); e.sat = m_satf;
        sb.push_back(e);
        m_acc = 0; m_cnt = 0; m_satf = 0;
      end
    end
  endtask

  // Scoreboard side: compare each correction word as it is handed off.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("m_corr", 32'(m_corr), 32'(e.corr));
        check("m_count", 32'(m_count), 32'(e.cnt));
        check("m_sat", 32'(m_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    m_acc = 0; m_cnt = 0; m_satf = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_code = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_corr", 32'(m_corr), 32'd0);
    check("rst_m_count", 32'(m_count), 32'd0);
    check("rst_m_sat", 32'(m_sat), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame: +4 +8 -4 = +8
    send(14'h0001, 1'b0);
    send(14'h0002, 1'b0);
    send(14'h3FFF, 1'b1);
    check("basic_m_valid", 32'(m_valid), 32'd1);
    check("basic_s_ready", 32'(s_ready), 32'd0);
    check("basic_corr", 32'(m_corr), 32'd8);
    check("basic_count", 32'(m_count), 32'd3);
    @(posedge clk); #1;
    check("basic_release_valid", 32'(m_valid), 32'd0);
    check("basic_release_ready", 32'(s_ready), 32'd1);

    // Reset mid-frame discards the partial sum
    send(14'h0001, 1'b0);
    send(14'h0001, 1'b0);
    send(14'h0001, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_corr", 32'(m_corr), 32'd0);
    check("midrst_m_count", 32'(m_count), 32'd0);
    check("midrst_m_sat", 32'(m_sat), 32'd0);
    m_acc = 0; m_cnt = 0; m_satf = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(14'h0001, 1'b0);
    send(14'h0001, 1'b1);
    check("postrst_corr", 32'(m_corr), 32'd8);
    check("postrst_count", 32'(m_count), 32'd2);

    // Backpressure: HOLD persists, held beat waits
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(14'd7, 1'b1);
    s_valid = 1'b1; s_code = 14'd9; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_m_corr", 32'(m_corr), 32'd28);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(14'd9, 1'b1);
    check("bp_next_corr", 32'(m_corr), 32'd36);

    // Positive saturation, then a clean negative frame
    send(14'h1FFF, 1'b0);
    send(14'h1FFF, 1'b0);
    send(14'h1FFF, 1'b1);
    check("psat_corr", 32'(m_corr), 32'h0FFFF);
    check("psat_flag", 32'(m_sat), 32'd1);
    send(14'h2000, 1'b1);
    check("neg_corr", 32'(m_corr), 32'h18000);
    check("neg_flag", 32'(m_sat), 32'd0);

    // Negative saturation; then accumulation continues from a clamp
    send(14'h2000, 1'b0);
    send(14'h2000, 1'b0);
    send(14'h2000, 1'b1);
    check("nsat_corr", 32'(m_corr), 32'h10000);
    check("nsat_flag", 32'(m_sat), 32'd1);
    send(14'h1FFF, 1'b0);
    send(14'h1FFF, 1'b0);
    send(14'h1FFF, 1'b0);
    send(14'h3FFF, 1'b1);
    check("clamp_cont_corr", 32'(m_corr), 32'd65531);
    check("clamp_cont_flag", 32'(m_sat), 32'd1);

    // Count saturation over 300 zero beats
    for (int i = 0; i < 300; i++) send(14'd0, (i == 299));
    check("cnt_sat_count", 32'(m_count), 32'd255);
    check("cnt_sat_corr", 32'(m_corr), 32'd0);

    // Back-to-back single-beat frames with a one-cycle bubble
    send(14'd5, 1'b1);
    check("b2b_first_corr", 32'(m_corr), 32'd20);
    send(14'd3, 1'b1);
    check("b2b_bubble", 32'(last_wait), 32'd1);
    check("b2b_second_corr", 32'(m_corr), 32'd12);
    check("b2b_second_count", 32'(m_count), 32'd1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
